key_press_filter: RTL and testbench

KEY_PRESS_FILTER -- requirements
Module: key_press_filter

---
 rtl/key_press_filter_pkg.sv | 23 ++
 rtl/key_press_filter_cycle_counter.sv | 30 +++
 rtl/key_press_filter.sv | 104 ++++++++++
 tb/tb_key_press_filter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/key_press_filter_pkg.sv
// Shared state encoding, default timing parameters and counter widths for the key press filter.
package key_press_filter_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } key_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_REPEAT_DELAY    = 32;
  localparam int DEFAULT_REPEAT_PERIOD   = 8;

  localparam int DEBOUNCE_WIDTH = 8;
  localparam int HOLD_WIDTH     = 16;

  // A period at or above the delay cannot be expressed as a reload; fall back to zero.
  function automatic int repeat_reload(input int delay, input int period);
    return (period < delay) ? (delay - period) : 0;
  endfunction

endpackage

// File: rtl/key_press_filter_cycle_counter.sv
// Loadable up-counter with synchronous clear and enable; saturates instead of wrapping.
module cycle_counter
  import key_press_filter_pkg::*;
#(
  parameter int WIDTH = HOLD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/key_press_filter.sv
// Debounces an already-synchronized key level and produces press/release pulses,
// the debounced level and an auto-repeat pulse while the key stays down.
module key_press_filter
  import key_press_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic filtered_data,
  output logic press,
  output logic release_pulse,
  output logic held,
  output logic repeat_pulse
);

  localparam logic [DEBOUNCE_WIDTH-1:0] DEBOUNCE_TARGET = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [DEBOUNCE_WIDTH-1:0] DEBOUNCE_ONE    = DEBOUNCE_WIDTH'(1);
  localparam logic [HOLD_WIDTH-1:0]     REPEAT_HIT      = HOLD_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [HOLD_WIDTH-1:0]     REPEAT_RELOAD   =
    HOLD_WIDTH'(repeat_reload(REPEAT_DELAY, REPEAT_PERIOD));

  key_state_e state;
  key_state_e next_state;
  logic [DEBOUNCE_WIDTH-1:0] debounce_count;
  logic [DEBOUNCE_WIDTH-1:0] next_debounce_count;
  logic [DEBOUNCE_WIDTH-1:0] debounce_inc;
  logic [HOLD_WIDTH-1:0]     hold_count;
  logic enter_pressed;
  logic enter_idle;
  logic repeat_hit;

  assign debounce_inc = debounce_count + DEBOUNCE_ONE;
  assign repeat_hit   = (state == PRESSED) && (hold_count == REPEAT_HIT);

  // The debounce count is always zero in IDLE and PRESSED, so each settled state
  // shares its logic with its wait state; a target of 1 skips the wait state.
  always_comb begin
    next_state          = state;
    next_debounce_count = '0;
    enter_pressed       = 1'b0;
    enter_idle          = 1'b0;
    case (state)
      IDLE, PRESS_WAIT: begin
        if (!filtered_data) begin
          next_state = IDLE;
        end else if (debounce_inc == DEBOUNCE_TARGET) begin
          next_state    = PRESSED;
          enter_pressed = 1'b1;
        end else begin
          next_state          = PRESS_WAIT;
          next_debounce_count = debounce_inc;
        end
      end
      PRESSED, RELEASE_WAIT: begin
        if (filtered_data) begin
          next_state = PRESSED;
        end else if (debounce_inc == DEBOUNCE_TARGET) begin
          next_state = IDLE;
          enter_idle = 1'b1;
        end else begin
          next_state          = RELEASE_WAIT;
          next_debounce_count = debounce_inc;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the transition decisions; a repeat is dropped when
  // the key starts releasing on the same edge, so it never lands outside PRESSED.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      debounce_count <= '0;
      press          <= 1'b0;
      release_pulse  <= 1'b0;
      held           <= 1'b0;
      repeat_pulse   <= 1'b0;
    end else begin
      state          <= next_state;
      debounce_count <= next_debounce_count;
      press          <= enter_pressed;
      release_pulse  <= enter_idle;
      held           <= (next_state == PRESSED) || (next_state == RELEASE_WAIT);
      repeat_pulse   <= repeat_hit && filtered_data;
    end
  end

  cycle_counter #(
    .WIDTH(HOLD_WIDTH)
  ) hold_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (enter_pressed),
    .load       (repeat_hit),
    .load_value (REPEAT_RELOAD),
    .enable     (state == PRESSED),
    .count      (hold_count)
  );

endmodule

// File: tb/tb_key_press_filter.sv
// Directed self-checking bench: a default-parameter filter plus a single-cycle-debounce instance.
module tb_key_press_filter;

  logic clk;
  logic reset;
  logic data;
  logic data_fast;
  logic press;
  logic release_pulse;
  logic held;
  logic repeat_pulse;
  logic press_fast;
  logic release_fast;
  logic held_fast;
  logic repeat_fast;

  int checks = 0;
  int errors = 0;

  key_press_filter #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (32),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .filtered_data(data),
    .press        (press),
    .release_pulse(release_pulse),
    .held         (held),
    .repeat_pulse (repeat_pulse)
  );

  key_press_filter #(
    .DEBOUNCE_CYCLES(1),
    .REPEAT_DELAY   (32),
    .REPEAT_PERIOD  (8)
  ) dut_fast (
    .clk          (clk),
    .reset        (reset),
    .filtered_data(data_fast),
    .press        (press_fast),
    .release_pulse(release_fast),
    .held         (held_fast),
    .repeat_pulse (repeat_fast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_main(input string tag, input logic exp_press, input logic exp_release,
                            input logic exp_held, input logic exp_repeat);
    check_output({tag, " press"}, press, exp_press);
    check_output({tag, " release"}, release_pulse, exp_release);
    check_output({tag, " held"}, held, exp_held);
    check_output({tag, " repeat"}, repeat_pulse, exp_repeat);
  endtask

  task automatic check_fast(input string tag, input logic exp_press, input logic exp_release,
                            input logic exp_held);
    check_output({tag, " press"}, press_fast, exp_press);
    check_output({tag, " release"}, release_fast, exp_release);
    check_output({tag, " held"}, held_fast, exp_held);
    check_output({tag, " repeat"}, repeat_fast, 1'b0);
  endtask

  task automatic apply_stimulus(input logic level, input logic level_fast);
    data      = level;
    data_fast = level_fast;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Each loop pass is one cycle: drive the level for cycle c, check the outputs
  // visible during cycle c, then step past the edge that samples the level.
  initial begin
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0);
    #2;
    check_main("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_fast("reset fast", 1'b0, 1'b0, 1'b0);
    next_cycle();
    check_main("reset held over edge", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    for (int c = 1; c <= 10; c++) begin
      apply_stimulus(c <= 3, 1'b0);
      check_main($sformatf("short high c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end

    for (int c = 1; c <= 64; c++) begin
      apply_stimulus(c <= 59, 1'b0);
      check_main($sformatf("hold repeat c%0d", c), c == 5, c == 64, (c >= 5) && (c <= 63),
                 (c == 37) || (c == 45) || (c == 53));
      next_cycle();
    end

    for (int c = 1; c <= 20; c++) begin
      apply_stimulus((c <= 8) || (c == 11) || (c == 12), 1'b0);
      check_main($sformatf("release glitch c%0d", c), c == 5, c == 17, (c >= 5) && (c <= 16),
                 1'b0);
      next_cycle();
    end

    for (int c = 1; c <= 7; c++) begin
      apply_stimulus(1'b1, 1'b0);
      check_main($sformatf("pre reset c%0d", c), c == 5, 1'b0, c >= 5, 1'b0);
      next_cycle();
    end
    apply_stimulus(1'b0, 1'b0);
    reset = 1'b0;
    #2;
    check_main("async reset mid press", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    next_cycle();

    for (int c = 1; c <= 6; c++) begin
      apply_stimulus(1'b0, 1'b0);
      check_main($sformatf("after reset c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end

    for (int c = 1; c <= 12; c++) begin
      apply_stimulus(c <= 6, 1'b0);
      check_main($sformatf("requalify c%0d", c), c == 5, c == 11, (c >= 5) && (c <= 10), 1'b0);
      next_cycle();
    end

    for (int c = 1; c <= 5; c++) begin
      apply_stimulus(1'b0, c == 1);
      check_fast($sformatf("single cycle c%0d", c), c == 2, c == 3, c == 2);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
